// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_REQ requesters, one transaction in flight.
// Optional WAIT watchdog enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   input  logic [NUM_REQ*4-1:0]          req_be,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_rdata,
   output logic                          resp_err,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_wdata,
   output logic [3:0]                    mem_be,
   input  logic [DATA_WIDTH-1:0]         mem_rdata,
   input  logic                          mem_valid,
   output logic                          busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]        grant_q, grant_d;
   logic                    mem_req_q, mem_req_d;
   logic                    mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]              mem_be_q, mem_be_d;
   logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
`ifdef DMEM_ARB_TIMEOUT_EN
   logic [31:0]             wd_cnt_q, wd_cnt_d;
   logic                    resp_err_q, resp_err_d;
`endif

   logic [IDX_W-1:0]        cand_s [NUM_REQ];
   logic                    pick_found_s;
   logic [IDX_W-1:0]        pick_idx_s;

   // Candidate i is the requester i positions above the round-robin pointer.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_s[gi] = IDX_W'((int'(rr_ptr_q) + gi) % NUM_REQ);
   end

   // First active requester scanning upward from rr_ptr.
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!pick_found_s && req_valid[cand_s[i]]) begin
            pick_found_s = 1'b1;
            pick_idx_s   = cand_s[i];
         end else begin
            pick_found_s = pick_found_s;
         end
      end
   end

   // Next-state and next-output computation for the IDLE/WAIT/RESP sequence.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_d      = grant_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      resp_valid_d = '0;
      resp_rdata_d = resp_rdata_q;
`ifdef DMEM_ARB_TIMEOUT_EN
      wd_cnt_d     = wd_cnt_q;
      resp_err_d   = resp_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_found_s) begin
               grant_d     = pick_idx_s;
               mem_req_d   = 1'b1;
               mem_we_d    = req_we[pick_idx_s];
               mem_addr_d  = req_addr[pick_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
               mem_wdata_d = req_wdata[pick_idx_s*DATA_WIDTH +: DATA_WIDTH];
               mem_be_d    = req_be[pick_idx_s*4 +: 4];
               state_d     = ST_WAIT;
`ifdef DMEM_ARB_TIMEOUT_EN
               wd_cnt_d    = 32'd0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (mem_valid) begin
               // Stores return zero so stale memory bus data never reaches a requester.
               resp_rdata_d = mem_we_q ? {DATA_WIDTH{1'b0}} : mem_rdata;
               resp_valid_d = NUM_REQ'(1) << grant_q;
               mem_req_d    = 1'b0;
               state_d      = ST_RESP;
`ifdef DMEM_ARB_TIMEOUT_EN
            end else if (wd_cnt_q == 32'(TIMEOUT_CYCLES)) begin
               resp_rdata_d = DATA_WIDTH'(32'hDEAD_BEEF);
               resp_valid_d = NUM_REQ'(1) << grant_q;
               resp_err_d   = 1'b1;
               mem_req_d    = 1'b0;
               state_d      = ST_RESP;
            end else begin
               wd_cnt_d = wd_cnt_q + 32'd1;
            end
`else
            end else begin
               state_d = ST_WAIT;
            end
`endif
         end
         ST_RESP: begin
            rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : grant_q + IDX_W'(1);
            state_d  = ST_IDLE;
`ifdef DMEM_ARB_TIMEOUT_EN
            resp_err_d = 1'b0;
`endif
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         grant_q      <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= 4'b0000;
         resp_valid_q <= '0;
         resp_rdata_q <= '0;
`ifdef DMEM_ARB_TIMEOUT_EN
         wd_cnt_q     <= 32'd0;
         resp_err_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_q      <= grant_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
`ifdef DMEM_ARB_TIMEOUT_EN
         wd_cnt_q     <= wd_cnt_d;
         resp_err_q   <= resp_err_d;
`endif
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_be     = mem_be_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign busy       = (state_q != ST_IDLE);
`ifdef DMEM_ARB_TIMEOUT_EN
   assign resp_err   = resp_err_q;
`else
   assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected transactions are queued at issue time and
// compared when mem_req rises (request fields) and when resp_valid pulses (response).
module tb_dmem_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct {
      int          idx;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
      logic        err;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N*4-1:0]  req_be;
   logic [N-1:0]    resp_valid;
   logic [DW-1:0]   resp_rdata;
   logic            resp_err;
   logic            mem_req, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [3:0]      mem_be;
   logic [DW-1:0]   mem_rdata;
   logic            mem_valid;
   logic            busy;

   logic [AW-1:0] a_addr [N];
   logic [DW-1:0] a_wdata [N];
   logic [3:0]    a_be [N];
   int            pending [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign req_addr[gi*AW +: AW]  = a_addr[gi];
      assign req_wdata[gi*DW +: DW] = a_wdata[gi];
      assign req_be[gi*4 +: 4]      = a_be[gi];
   end

   dmem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_valid(mem_valid), .busy(busy)
   );

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   grant_cyc = 0;
   int   last_resp_cyc = 0;
   int   resp_cnt = 0;
   txn_t sb_q [$];
   txn_t pend_q [$];
   int   resp_cyc_q [$];

   logic mem_auto = 1'b1;
   int   mem_lat = 0;
   int   lat_cnt = 0;
   int   kick_req = 0;
   int   kick_ack = 0;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h1234_5678;
      return (a * 32'h9E37_79B1) ^ 32'h0F0F_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input int i, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int n);
      req_we[i]  = we;
      a_addr[i]  = addr;
      a_wdata[i] = wdata;
      a_be[i]    = be;
      pending[i] = n;
      req_valid[i] = 1'b1;
   endtask

   task automatic push(input int i, input logic err);
      txn_t e;
      e.idx   = i;
      e.we    = req_we[i];
      e.addr  = a_addr[i];
      e.wdata = a_wdata[i];
      e.be    = a_be[i];
      e.err   = err;
      e.rdata = err ? 32'hDEAD_BEEF : (req_we[i] ? 32'h0 : mem_fn(a_addr[i]));
      sb_q.push_back(e);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      bit done = 1'b0;
      for (int k = 0; k < budget; k++) begin
         tick();
         if (!busy && req_valid == '0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) chk({tag, "_bound"}, 64'd0, 64'd1);
   endtask

   // Memory model: replies mem_lat cycles after seeing mem_req, or on a manual kick.
   always @(posedge clk) begin
      #1;
      if (mem_valid) begin
         mem_valid = 1'b0;
      end else if (kick_req != kick_ack) begin
         kick_ack  = kick_req;
         mem_valid = 1'b1;
         mem_rdata = mem_fn(mem_addr);
      end else if (mem_auto && mem_req) begin
         if (lat_cnt >= mem_lat) begin
            mem_valid = 1'b1;
            mem_rdata = mem_fn(mem_addr);
            lat_cnt   = 0;
         end else begin
            lat_cnt++;
         end
      end else begin
         lat_cnt = 0;
      end
   end

   // Monitor: check issued fields at grant and responses against the scoreboard.
   logic prev_req = 1'b0;
   txn_t mon_e;
   always @(posedge clk) begin
      #1;
      cyc++;
      if (!rst_n) begin
         prev_req = 1'b0;
      end else begin
         if (mem_req && !prev_req) begin
            grant_cyc = cyc;
            if (sb_q.size() == 0) begin
               chk("unexpected_grant", 64'd1, 64'd0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("mem_addr", 64'(mem_addr), 64'(mon_e.addr));
               chk("mem_we", 64'(mem_we), 64'(mon_e.we));
               chk("mem_be", 64'(mem_be), 64'(mon_e.be));
               chk("mem_wdata", 64'(mem_wdata), 64'(mon_e.wdata));
               pend_q.push_back(mon_e);
            end
         end
         prev_req = mem_req;
         if (resp_valid != '0) begin
            resp_cnt++;
            last_resp_cyc = cyc;
            resp_cyc_q.push_back(cyc);
            if (pend_q.size() == 0) begin
               chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
               mon_e = pend_q.pop_front();
               chk("resp_valid", 64'(resp_valid), 64'(1) << mon_e.idx);
               chk("resp_rdata", 64'(resp_rdata), 64'(mon_e.rdata));
               chk("resp_err", 64'(resp_err), 64'(mon_e.err));
               if (pending[mon_e.idx] > 0) pending[mon_e.idx]--;
               if (pending[mon_e.idx] == 0) req_valid[mon_e.idx] = 1'b0;
            end
         end
      end
   end

   int base;

   initial begin
      req_valid = '0;
      req_we    = '0;
      mem_valid = 1'b0;
      mem_rdata = '0;
      for (int i = 0; i < N; i++) begin
         a_addr[i] = '0; a_wdata[i] = '0; a_be[i] = 4'h0; pending[i] = 0;
      end

      rst_n = 1'b0;
      repeat (2) tick();
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      rst_n = 1'b1;
      tick();

      // Single load from requester 1, memory answers after 3 cycles.
      mem_lat = 3;
      set_req(1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1);
      push(1, 1'b0);
      tick();
      chk("load_mem_req", 64'(mem_req), 64'd1);
      chk("load_busy", 64'(busy), 64'd1);
      wait_idle("load", 50);
      chk("load_latency", 64'(last_resp_cyc - grant_cyc), 64'd4);
      chk("load_rdata_hold", 64'(resp_rdata), 64'h1234_5678);

      // Store from requester 2.
      mem_lat = 1;
      set_req(2, 1'b1, 32'h0000_0200, 32'h00AB_00AB, 4'b0100, 1);
      push(2, 1'b0);
      wait_idle("store", 50);

      // Flush: requester 1 drops its request while in WAIT.
      mem_auto = 1'b0;
      set_req(1, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 1);
      push(1, 1'b0);
      tick();
      chk("flush_mem_req", 64'(mem_req), 64'd1);
      req_valid[1] = 1'b0;
      pending[1]   = 0;
      repeat (3) tick();
      chk("flush_hold", 64'(mem_req), 64'd1);
      base = resp_cnt;
      kick_req++;
      wait_idle("flush", 50);
      chk("flush_resp", 64'(resp_cnt - base), 64'd1);

      // Reset while a store from requester 3 sits in WAIT.
      set_req(3, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'b1001, 1);
      push(3, 1'b0);
      repeat (2) tick();
      chk("pre_rst_mem_req", 64'(mem_req), 64'd1);
      base = resp_cnt;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_mem_req", 64'(mem_req), 64'd0);
      chk("mid_rst_mem_we", 64'(mem_we), 64'd0);
      chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("mid_rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("mid_rst_mem_be", 64'(mem_be), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      req_valid = '0;
      for (int i = 0; i < N; i++) pending[i] = 0;
      sb_q.delete();
      pend_q.delete();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("mid_rst_no_resp", 64'(resp_cnt - base), 64'd0);
      mem_auto = 1'b1;

      // Fairness: all four held, requester 0 needs two transactions.
      mem_lat = 0;
      resp_cyc_q.delete();
      for (int i = 0; i < N; i++)
         set_req(i, 1'b0, 32'h0000_1000 + 32'(i * 16), 32'h0, 4'hF, (i == 0) ? 2 : 1);
      for (int i = 0; i < N; i++) push(i, 1'b0);
      push(0, 1'b0);
      wait_idle("fair", 100);
      chk("fair_count", 64'(resp_cyc_q.size()), 64'd5);
      for (int k = 1; k < resp_cyc_q.size(); k++)
         chk("fair_spacing", 64'(resp_cyc_q[k] - resp_cyc_q[k-1]), 64'd3);

`ifdef DMEM_ARB_TIMEOUT_EN
      // Watchdog: memory never answers.
      mem_auto = 1'b0;
      set_req(2, 1'b0, 32'h0000_0500, 32'h0, 4'hF, 1);
      push(2, 1'b1);
      wait_idle("timeout", 60);
      chk("timeout_latency", 64'(last_resp_cyc - grant_cyc), 64'd9);
      base = resp_cnt;
      kick_req++;
      repeat (3) tick();
      chk("stray_busy", 64'(busy), 64'd0);
      chk("stray_no_resp", 64'(resp_cnt - base), 64'd0);
      mem_auto = 1'b1;
`endif

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      chk("pend_empty", 64'(pend_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
